sbr_batch_scheduler: RTL and testbench

SBR_BATCH_SCHEDULER -- requirements
Module: sbr_batch_scheduler

---
 rtl/sbr_batch_scheduler_pkg.sv | 45 ++++
 rtl/sbr_batch_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sbr_batch_scheduler.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbr_batch_scheduler_pkg.sv
// Shared widths, state encoding and output-flag decode for the SBR batch scheduler.
// Widths match the SBR table they sit beside in the DRAM scheduler top.
package sbr_batch_scheduler_pkg;

  localparam int MAX_SBR_ENTRIES  = 8;
  localparam int SBR_ID_WIDTH     = 3;
  localparam int REQUEST_ID_WIDTH = 8;
  localparam int BANK_GROUP_WIDTH = 2;
  localparam int BANK_WIDTH       = 2;
  localparam int SRR_ID_WIDTH     = 6;
  localparam int SBR_STATE_WIDTH  = 3;

  typedef enum logic [SBR_STATE_WIDTH-1:0] {
    ST_IDLE   = 3'd0,
    ST_FIND   = 3'd1,
    ST_READ   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_CLEAR  = 3'd5,
    ST_DONE   = 3'd6
  } sbr_state_e;

  typedef struct packed {
    logic busy;
    logic find_en;
    logic issue_valid;
    logic upd_en;
    logic clear;
    logic done;
  } sbr_flags_t;

  // Strobes are registered together with the state they belong to.
  function automatic sbr_flags_t flags_for(sbr_state_e s);
    sbr_flags_t f;
    f             = '0;
    f.busy        = (s != ST_IDLE);
    f.find_en     = (s == ST_FIND);
    f.issue_valid = (s == ST_ISSUE);
    f.upd_en      = (s == ST_UPDATE);
    f.clear       = (s == ST_CLEAR);
    f.done        = (s == ST_DONE);
    return f;
  endfunction

endpackage

// File: rtl/sbr_batch_scheduler.sv
// Picks the SBR entry with the most pending requests, offers it downstream as a batch,
// retires it in the table, and repeats until the table is empty, the cap is hit, or abort.
module sbr_batch_scheduler
  import sbr_batch_scheduler_pkg::*;
#(
  parameter int MAX_BATCHES = MAX_SBR_ENTRIES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        tbl_clear,
  output logic                        tbl_find_max_en,
  input  logic [SBR_ID_WIDTH-1:0]     tbl_max_addr,
  input  logic [REQUEST_ID_WIDTH-1:0] tbl_max_requests,
  output logic [SBR_ID_WIDTH-1:0]     tbl_rd_addr,
  input  logic [BANK_GROUP_WIDTH-1:0] tbl_rd_bank_group,
  input  logic [BANK_WIDTH-1:0]       tbl_rd_bank,
  input  logic [SRR_ID_WIDTH-1:0]     tbl_rd_head_srr,
  input  logic [SRR_ID_WIDTH-1:0]     tbl_rd_row_count,
  input  logic [SRR_ID_WIDTH-1:0]     tbl_rd_tail_srr,
  output logic                        tbl_upd_en,
  output logic [SBR_ID_WIDTH-1:0]     tbl_upd_addr,
  output logic [REQUEST_ID_WIDTH-1:0] tbl_upd_total_requests,
  output logic [SRR_ID_WIDTH-1:0]     tbl_upd_row_count,
  output logic [SRR_ID_WIDTH-1:0]     tbl_upd_tail_srr,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [BANK_GROUP_WIDTH-1:0] issue_bank_group,
  output logic [BANK_WIDTH-1:0]       issue_bank,
  output logic [SRR_ID_WIDTH-1:0]     issue_head_srr,
  output logic [REQUEST_ID_WIDTH-1:0] issue_total_requests
);

  localparam int CNT_W = $clog2(MAX_BATCHES + 1);

  sbr_state_e                  state;
  sbr_flags_t                  flags;
  logic [CNT_W-1:0]            batch_cnt;
  logic [CNT_W-1:0]            cnt_inc;
  logic                        held;
  logic [REQUEST_ID_WIDTH-1:0] total_q;
  logic [BANK_GROUP_WIDTH-1:0] bg_q;
  logic [BANK_WIDTH-1:0]       bank_q;
  logic [SRR_ID_WIDTH-1:0]     head_q;
  logic [SRR_ID_WIDTH-1:0]     row_q;
  logic [SRR_ID_WIDTH-1:0]     tail_q;

  assign cnt_inc = (batch_cnt == CNT_W'(MAX_BATCHES)) ? batch_cnt : batch_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      flags       <= '0;
      batch_cnt   <= '0;
      held        <= 1'b0;
      tbl_rd_addr <= '0;
      total_q     <= '0;
      bg_q        <= '0;
      bank_q      <= '0;
      head_q      <= '0;
      row_q       <= '0;
      tail_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_FIND;
            flags <= flags_for(ST_FIND);
          end
        end
        ST_FIND: begin
          if (abort || (tbl_max_requests == '0) || (batch_cnt == CNT_W'(MAX_BATCHES))) begin
            state <= ST_CLEAR;
            flags <= flags_for(ST_CLEAR);
          end else begin
            tbl_rd_addr <= tbl_max_addr;
            total_q     <= tbl_max_requests;
            state       <= ST_READ;
            flags       <= flags_for(ST_READ);
          end
        end
        ST_READ: begin
          held <= 1'b0;
          if (abort) begin
            state <= ST_CLEAR;
            flags <= flags_for(ST_CLEAR);
          end else begin
            state <= ST_ISSUE;
            flags <= flags_for(ST_ISSUE);
          end
        end
        ST_ISSUE: begin
          // Read data arrives in the first ISSUE cycle; freeze it so the payload cannot move.
          if (!held) begin
            held   <= 1'b1;
            bg_q   <= tbl_rd_bank_group;
            bank_q <= tbl_rd_bank;
            head_q <= tbl_rd_head_srr;
            row_q  <= tbl_rd_row_count;
            tail_q <= tbl_rd_tail_srr;
          end
          if (issue_ready && abort) begin
            batch_cnt <= cnt_inc;
            state     <= ST_CLEAR;
            flags     <= flags_for(ST_CLEAR);
          end else if (issue_ready) begin
            state <= ST_UPDATE;
            flags <= flags_for(ST_UPDATE);
          end else if (abort) begin
            state <= ST_CLEAR;
            flags <= flags_for(ST_CLEAR);
          end
        end
        ST_UPDATE: begin
          batch_cnt <= cnt_inc;
          if (abort) begin
            state <= ST_CLEAR;
            flags <= flags_for(ST_CLEAR);
          end else begin
            state <= ST_FIND;
            flags <= flags_for(ST_FIND);
          end
        end
        ST_CLEAR: begin
          batch_cnt <= '0;
          state     <= ST_DONE;
          flags     <= flags_for(ST_DONE);
        end
        ST_DONE: begin
          state <= ST_IDLE;
          flags <= flags_for(ST_IDLE);
        end
        default: begin
          state <= ST_IDLE;
          flags <= '0;
        end
      endcase
    end
  end

  assign busy            = flags.busy;
  assign done            = flags.done;
  assign tbl_clear       = flags.clear;
  assign tbl_find_max_en = flags.find_en;
  assign tbl_upd_en      = flags.upd_en;
  assign issue_valid     = flags.issue_valid;

  assign issue_bank_group     = !issue_valid ? '0 : (held ? bg_q   : tbl_rd_bank_group);
  assign issue_bank           = !issue_valid ? '0 : (held ? bank_q : tbl_rd_bank);
  assign issue_head_srr       = !issue_valid ? '0 : (held ? head_q : tbl_rd_head_srr);
  assign issue_total_requests = issue_valid ? total_q : '0;

  // A served entry is written back with zero requests; the SRR chain bookkeeping is kept.
  assign tbl_upd_addr           = tbl_rd_addr;
  assign tbl_upd_total_requests = '0;
  assign tbl_upd_row_count      = tbl_upd_en ? row_q  : '0;
  assign tbl_upd_tail_srr       = tbl_upd_en ? tail_q : '0;

endmodule

// File: tb/tb_sbr_batch_scheduler.sv
// Bench for sbr_batch_scheduler: behavioural SBR table, scoreboard of expected batches.
module tb_sbr_batch_scheduler;
  import sbr_batch_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, issue_ready = 1'b0, sel = 1'b0, tb_load = 1'b0;
  int   passed = 0, total = 0;
  int   cyc = 0, upd_cnt = 0, clr_cnt = 0, done_cnt = 0, clr_cyc = 0, done_cyc = 0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] tot;
  } exp_t;
  exp_t       sbq[$];
  logic [2:0] exp_last = '0;

  // Behavioural table: field contents are fixed functions of the entry index.
  function automatic logic [1:0] f_bg(logic [2:0] a);   return a[1:0];                 endfunction
  function automatic logic [1:0] f_bank(logic [2:0] a); return {a[0], a[2]};           endfunction
  function automatic logic [5:0] f_head(logic [2:0] a); return 6'(a) * 6'd7 + 6'd2;    endfunction
  function automatic logic [5:0] f_row(logic [2:0] a);  return 6'(a) + 6'd4;           endfunction
  function automatic logic [5:0] f_tail(logic [2:0] a); return 6'(a) * 6'd7 + 6'd5;    endfunction

  logic [7:0] cnt_mem  [8];
  logic [7:0] cnt_init [8];
  logic [2:0] rd_q = '0;
  logic [2:0] max_a;
  logic [7:0] max_r;

  logic       a_busy, a_done, a_clear, a_find, a_upd_en, a_valid;
  logic       b_busy, b_done, b_clear, b_find, b_upd_en, b_valid;
  logic [2:0] a_rd_addr, a_upd_addr, b_rd_addr, b_upd_addr;
  logic [7:0] a_upd_tot, a_tot, b_upd_tot, b_tot;
  logic [5:0] a_upd_row, a_upd_tail, a_head, b_upd_row, b_upd_tail, b_head;
  logic [1:0] a_bg, a_bank, b_bg, b_bank;

  logic       m_busy, m_done, m_clear, m_find, m_upd_en, m_valid;
  logic [2:0] m_rd_addr, m_upd_addr;
  logic [7:0] m_upd_tot, m_tot;
  logic [5:0] m_upd_row, m_upd_tail, m_head;
  logic [1:0] m_bg, m_bank;

  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_done     = sel ? b_done     : a_done;
  assign m_clear    = sel ? b_clear    : a_clear;
  assign m_find     = sel ? b_find     : a_find;
  assign m_upd_en   = sel ? b_upd_en   : a_upd_en;
  assign m_valid    = sel ? b_valid    : a_valid;
  assign m_rd_addr  = sel ? b_rd_addr  : a_rd_addr;
  assign m_upd_addr = sel ? b_upd_addr : a_upd_addr;
  assign m_upd_tot  = sel ? b_upd_tot  : a_upd_tot;
  assign m_tot      = sel ? b_tot      : a_tot;
  assign m_upd_row  = sel ? b_upd_row  : a_upd_row;
  assign m_upd_tail = sel ? b_upd_tail : a_upd_tail;
  assign m_head     = sel ? b_head     : a_head;
  assign m_bg       = sel ? b_bg       : a_bg;
  assign m_bank     = sel ? b_bank     : a_bank;

  always_comb begin
    max_a = '0;
    max_r = '0;
    for (int i = 0; i < 8; i++) begin
      if (cnt_mem[i] > max_r) begin
        max_r = cnt_mem[i];
        max_a = 3'(i);
      end
    end
  end

  always @(posedge clk) begin
    rd_q <= m_rd_addr;
    if (tb_load) begin
      for (int i = 0; i < 8; i++) cnt_mem[i] <= cnt_init[i];
    end else if (m_clear) begin
      for (int i = 0; i < 8; i++) cnt_mem[i] <= '0;
    end else if (m_upd_en) begin
      cnt_mem[m_upd_addr] <= m_upd_tot;
    end
  end

  sbr_batch_scheduler dut_a (
    .clk(clk), .rst(rst), .start(start && !sel), .abort(abort),
    .busy(a_busy), .done(a_done), .tbl_clear(a_clear), .tbl_find_max_en(a_find),
    .tbl_max_addr(max_a), .tbl_max_requests(max_r), .tbl_rd_addr(a_rd_addr),
    .tbl_rd_bank_group(f_bg(rd_q)), .tbl_rd_bank(f_bank(rd_q)), .tbl_rd_head_srr(f_head(rd_q)),
    .tbl_rd_row_count(f_row(rd_q)), .tbl_rd_tail_srr(f_tail(rd_q)),
    .tbl_upd_en(a_upd_en), .tbl_upd_addr(a_upd_addr), .tbl_upd_total_requests(a_upd_tot),
    .tbl_upd_row_count(a_upd_row), .tbl_upd_tail_srr(a_upd_tail),
    .issue_valid(a_valid), .issue_ready(issue_ready), .issue_bank_group(a_bg),
    .issue_bank(a_bank), .issue_head_srr(a_head), .issue_total_requests(a_tot)
  );

  sbr_batch_scheduler #(.MAX_BATCHES(2)) dut_b (
    .clk(clk), .rst(rst), .start(start && sel), .abort(abort),
    .busy(b_busy), .done(b_done), .tbl_clear(b_clear), .tbl_find_max_en(b_find),
    .tbl_max_addr(max_a), .tbl_max_requests(max_r), .tbl_rd_addr(b_rd_addr),
    .tbl_rd_bank_group(f_bg(rd_q)), .tbl_rd_bank(f_bank(rd_q)), .tbl_rd_head_srr(f_head(rd_q)),
    .tbl_rd_row_count(f_row(rd_q)), .tbl_rd_tail_srr(f_tail(rd_q)),
    .tbl_upd_en(b_upd_en), .tbl_upd_addr(b_upd_addr), .tbl_upd_total_requests(b_upd_tot),
    .tbl_upd_row_count(b_upd_row), .tbl_upd_tail_srr(b_upd_tail),
    .issue_valid(b_valid), .issue_ready(issue_ready), .issue_bank_group(b_bg),
    .issue_bank(b_bank), .issue_head_srr(b_head), .issue_total_requests(b_tot)
  );

  // Advance one cycle; handshakes and strobes of the ending cycle go through the scoreboard.
  task automatic tick();
    logic hs, upd, clr, dn;
    logic [2:0] a, ua;
    logic [7:0] t, ut;
    logic [1:0] bg, bk;
    logic [5:0] hd, ur, utl;
    exp_t e;
    hs = m_valid && issue_ready;
    a = m_rd_addr; t = m_tot; bg = m_bg; bk = m_bank; hd = m_head;
    upd = m_upd_en; ua = m_upd_addr; ut = m_upd_tot; ur = m_upd_row; utl = m_upd_tail;
    clr = m_clear; dn = m_done;
    @(posedge clk); #1;
    cyc++;
    if (hs) begin
      total++;
      if (sbq.size() == 0) begin
        $display("FAIL sb_issue unexpected batch: addr=%0d tot=%0d, required no issue", a, t);
      end else begin
        e = sbq.pop_front();
        exp_last = e.addr;
        if ({a, t, bg, bk, hd} !== {e.addr, e.tot, f_bg(e.addr), f_bank(e.addr), f_head(e.addr)})
          $display("FAIL sb_issue got addr=%0d tot=%0d bg=%0d bank=%0d head=%0d, required addr=%0d tot=%0d bg=%0d bank=%0d head=%0d",
                   a, t, bg, bk, hd, e.addr, e.tot, f_bg(e.addr), f_bank(e.addr), f_head(e.addr));
        else passed++;
      end
    end
    if (upd) begin
      upd_cnt++;
      total++;
      if ({ua, ut, ur, utl} !== {exp_last, 8'd0, f_row(exp_last), f_tail(exp_last)})
        $display("FAIL sb_update got addr=%0d tot=%0d row=%0d tail=%0d, required addr=%0d tot=0 row=%0d tail=%0d",
                 ua, ut, ur, utl, exp_last, f_row(exp_last), f_tail(exp_last));
      else passed++;
    end
    if (clr) begin clr_cnt++; clr_cyc = cyc; end
    if (dn)  begin done_cnt++; done_cyc = cyc; end
  endtask

  task automatic load_table(input logic [63:0] v);
    for (int i = 0; i < 8; i++) cnt_init[i] = v[i*8 +: 8];
    tb_load = 1'b1;
    tick();
    tb_load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int bound);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < bound && done_cnt == d0; k++) tick();
    total++;
    if (done_cnt == d0) $display("FAIL done_timeout no done within %0d cycles, required done", bound);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({a_busy, a_done, a_clear, a_valid, a_upd_en} !== 5'b0)
      $display("FAIL reset_flags got %b, required 00000", {a_busy, a_done, a_clear, a_valid, a_upd_en});
    else passed++;
    total++;
    if ({a_rd_addr, a_tot, a_head} !== '0)
      $display("FAIL reset_data got %h, required 0", {a_rd_addr, a_tot, a_head});
    else passed++;
    total++;
    if ({b_busy, b_valid, b_rd_addr} !== '0)
      $display("FAIL reset_b got %h, required 0", {b_busy, b_valid, b_rd_addr});
    else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({a_busy, b_busy, a_clear, b_clear} !== 4'b0)
      $display("FAIL reset_release got %b, required 0000 (no clear from reset)", {a_busy, b_busy, a_clear, b_clear});
    else passed++;
  endtask

  task automatic test_basic();
    int u0, c0;
    sel = 1'b0; issue_ready = 1'b1;
    load_table({40'd0, 8'd5, 8'd7, 8'd3});
    sbq.push_back('{3'd1, 8'd7});
    sbq.push_back('{3'd2, 8'd5});
    sbq.push_back('{3'd0, 8'd3});
    u0 = upd_cnt; c0 = clr_cnt;
    pulse_start();
    run_to_done(80);
    total++;
    if (sbq.size() != 0) $display("FAIL basic_pending got %0d batches left, required 0", sbq.size());
    else passed++;
    total++;
    if (upd_cnt - u0 != 3) $display("FAIL basic_updates got %0d, required 3", upd_cnt - u0);
    else passed++;
    total++;
    if (clr_cnt - c0 != 1 || done_cyc != clr_cyc + 1)
      $display("FAIL basic_clear got clears=%0d done-clear=%0d, required clears=1 gap=1", clr_cnt - c0, done_cyc - clr_cyc);
    else passed++;
    tick();
    total++;
    if (m_busy !== 1'b0) $display("FAIL basic_idle got busy=%b, required 0", m_busy);
    else passed++;
  endtask

  task automatic test_empty();
    logic seen_valid;
    sel = 1'b0; issue_ready = 1'b1;
    load_table(64'd0);
    pulse_start();
    seen_valid = m_valid;
    total++;
    if ({m_busy, m_find, m_clear, m_done} !== 4'b1100)
      $display("FAIL empty_find got busy/find/clear/done=%b, required 1100", {m_busy, m_find, m_clear, m_done});
    else passed++;
    tick();
    seen_valid |= m_valid;
    total++;
    if ({m_clear, m_done} !== 2'b10) $display("FAIL empty_clear got clear/done=%b, required 10", {m_clear, m_done});
    else passed++;
    tick();
    seen_valid |= m_valid;
    total++;
    if ({m_clear, m_done} !== 2'b01) $display("FAIL empty_done got clear/done=%b, required 01 on cycle 3", {m_clear, m_done});
    else passed++;
    tick();
    total++;
    if (seen_valid !== 1'b0 || m_busy !== 1'b0)
      $display("FAIL empty_novalid got valid_seen=%b busy=%b, required 0 0", seen_valid, m_busy);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [20:0] p;
    int k;
    sel = 1'b0; issue_ready = 1'b0;
    load_table({48'd0, 8'd9, 8'd0});
    sbq.push_back('{3'd1, 8'd9});
    pulse_start();
    for (k = 0; k < 20 && !m_valid; k++) tick();
    total++;
    if (!m_valid) $display("FAIL bp_valid_timeout got no issue_valid in 20 cycles, required valid");
    else passed++;
    p = {m_rd_addr, m_tot, m_bg, m_bank, m_head};
    for (int i = 0; i < 10; i++) begin
      start = (i == 3);
      tick();
      start = 1'b0;
      total++;
      if (!m_valid || {m_rd_addr, m_tot, m_bg, m_bank, m_head} !== p)
        $display("FAIL bp_stable cycle %0d got valid=%b payload=%h, required valid=1 payload=%h",
                 i + 2, m_valid, {m_rd_addr, m_tot, m_bg, m_bank, m_head}, p);
      else passed++;
    end
    issue_ready = 1'b1;
    tick();
    total++;
    if (m_valid !== 1'b0 || m_upd_en !== 1'b1 || sbq.size() != 0)
      $display("FAIL bp_handshake got valid=%b upd=%b pending=%0d, required 0 1 0", m_valid, m_upd_en, sbq.size());
    else passed++;
    run_to_done(20);
  endtask

  task automatic test_abort();
    int u0, nv;
    logic found;
    sel = 1'b0; issue_ready = 1'b1;
    load_table({40'd0, 8'd5, 8'd7, 8'd3});
    sbq.push_back('{3'd1, 8'd7});
    sbq.push_back('{3'd2, 8'd5});
    u0 = upd_cnt; nv = 0; found = 1'b0;
    pulse_start();
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_valid) begin
        nv++;
        if (nv == 2) found = 1'b1;
      end
      if (!found) tick();
    end
    total++;
    if (!found) $display("FAIL abort_timeout got %0d valid cycles, required 2", nv);
    else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({m_clear, m_upd_en} !== 2'b10) $display("FAIL abort_clear got clear/upd=%b, required 10", {m_clear, m_upd_en});
    else passed++;
    tick();
    total++;
    if (m_done !== 1'b1) $display("FAIL abort_done got done=%b, required 1", m_done);
    else passed++;
    tick();
    total++;
    if (upd_cnt - u0 != 1 || sbq.size() != 0 || m_busy !== 1'b0)
      $display("FAIL abort_tally got updates=%0d pending=%0d busy=%b, required 1 0 0", upd_cnt - u0, sbq.size(), m_busy);
    else passed++;
  endtask

  task automatic test_max_batches();
    int u0;
    sel = 1'b1; issue_ready = 1'b1;
    load_table({32'd0, 8'd8, 8'd2, 8'd6, 8'd4});
    sbq.push_back('{3'd3, 8'd8});
    sbq.push_back('{3'd1, 8'd6});
    u0 = upd_cnt;
    pulse_start();
    run_to_done(60);
    total++;
    if (sbq.size() != 0 || upd_cnt - u0 != 2)
      $display("FAIL max_batches got pending=%0d updates=%0d, required 0 2", sbq.size(), upd_cnt - u0);
    else passed++;
    tick();
    issue_ready = 1'b0;
    load_table({32'd0, 8'd8, 8'd2, 8'd6, 8'd4});
    pulse_start();
    for (int k = 0; k < 20 && !m_valid; k++) tick();
    total++;
    if (!m_valid) $display("FAIL rst_mid_issue_setup got no issue_valid, required valid before reset");
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if ({m_busy, m_valid, m_rd_addr, m_tot} !== '0)
      $display("FAIL rst_mid_issue got busy=%b valid=%b addr=%0d tot=%0d, required all 0", m_busy, m_valid, m_rd_addr, m_tot);
    else passed++;
    tick();
    rst = 1'b0;
    tick();
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) cnt_init[i] = '0;
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_abort();
    test_max_batches();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
